mole_game_core: RTL and testbench

//  Parametrised reaction ("whack-a-mole") game engine for the board's LED/switch bank.
//  An LFSR picks one of N_CH lamps each game tick. The player answers by raising the matching switch.

---
 rtl/mole_game_pkg.sv | 41 ++++
 rtl/mole_game_if.sv | 36 +++
 rtl/mole_game_lfsr_prng.sv | 26 ++
 rtl/mole_game_core.sv | 155 +++++++++++++++
 tb/tb_mole_game_core.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mole_game_pkg.sv
// Shared state encodings and display helper
// for the reaction game core.
package mole_game_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ARM  = 3'd1;
  localparam state_t S_SHOW = 3'd2;
  localparam state_t S_WIN  = 3'd3;
  localparam state_t S_LOSE = 3'd4;

  // active-high segments, bit6=a .. bit0=g
  function automatic logic [6:0] seg7_hex(
    input logic [3:0] v
  );
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mole_game_if.sv
// Board-side bundle of the game core:
// start/switch inputs and lamp/score/display outputs.
interface mole_game_if #(
  parameter int N_CH = 16
);
  import mole_game_pkg::*;

  logic            start;
  logic [N_CH-1:0] sw;
  logic [N_CH-1:0] led;
  logic [3:0]      score;
  logic [2:0]      misses;
  logic            busy;
  logic [6:0]      disp;

  modport master (
    output start,
    output sw,
    input  led,
    input  score,
    input  misses,
    input  busy,
    input  disp
  );

  modport slave (
    input  start,
    input  sw,
    output led,
    output score,
    output misses,
    output busy,
    output disp
  );

endinterface

// File: rtl/mole_game_lfsr_prng.sv
// Right-shifting Fibonacci LFSR used to pick
// the lamp; reseeds itself if it ever reaches zero.
module lfsr_prng #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = 16'h128A,
  parameter logic [W-1:0] SEED = 16'h2CAD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      if (q == '0) begin
        q <= SEED;
      end else begin
        q <= {^(q & TAPS), q[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole engine: tick divider, switch
// synchronizer, game FSM and lamp/score outputs.
module mole_game_core
  import mole_game_pkg::*;
#(
  parameter int              N_CH      = 16,
  parameter int              CLK_DIV   = 25000000,
  parameter int              LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'h128A,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'h2CAD,
  parameter int              WIN_SCORE = 3,
  parameter int              MAX_MISS  = 3
) (
  input logic        clk,
  input logic        rst,
  mole_game_if.slave io
);

  localparam int TW = $clog2(N_CH);
  localparam int CW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t state;

  logic [CW-1:0]     cnt;
  logic              tick;
  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr;
  logic [TW-1:0]     tgt;
  logic [N_CH-1:0]   tgt_oh;
  logic [N_CH-1:0]   lose_pat;

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] hist;
  logic [N_CH-1:0] rise;
  logic            hit;
  logic            wrong;

  logic [3:0] score;
  logic [2:0] misses;

  // divider parked in IDLE so the lamp sequence
  // is fixed until the first game starts
  assign tick = (state != S_IDLE) &&
                (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_IDLE || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  lfsr_prng #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (tick),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr;
  assign tgt         = lfsr[TW-1:0];
  assign tgt_oh      = N_CH'(1) << tgt;

  // history resets high: a switch held
  // through reset can never score
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '1;
    end else begin
      sync1 <= io.sw;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise  = sync2 & ~hist;
  assign hit   = |(rise & tgt_oh);
  assign wrong = |(rise & ~tgt_oh);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      score  <= '0;
      misses <= '0;
    end else begin
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (io.start) begin
            state  <= S_ARM;
            score  <= '0;
            misses <= '0;
          end
        end
        S_ARM: begin
          if (tick) begin
            state <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (hit) begin
            score <= score + 1'b1;
            if (score == 4'(WIN_SCORE - 1)) begin
              state <= S_WIN;
            end else begin
              state <= S_ARM;
            end
          end else if (wrong || tick) begin
            misses <= misses + 1'b1;
            if (misses == 3'(MAX_MISS - 1)) begin
              state <= S_LOSE;
            end else begin
              state <= S_ARM;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    lose_pat = '0;
    for (int i = 0; i < N_CH; i++) begin
      lose_pat[i] = i[0];
    end
  end

  always_comb begin
    io.led = '0;
    unique case (1'b1)
      (state == S_SHOW): io.led = tgt_oh;
      (state == S_WIN):  io.led = '1;
      (state == S_LOSE): io.led = lose_pat;
      default:           io.led = '0;
    endcase
  end

  assign io.score  = score;
  assign io.misses = misses;
  assign io.busy   = (state == S_ARM) ||
                     (state == S_SHOW);
  assign io.disp   = ~seg7_hex(score);

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core with a small
// divider/LFSR model to predict the lit lamp.
module tb_mole_game_core;

  localparam logic [15:0] SEED = 16'h2CAD;
  localparam logic [15:0] TAPS = 16'h128A;

  logic clk;
  logic rst;

  int total;
  int bad;

  logic [1:0]  m_cnt;
  logic [15:0] m_lfsr;
  logic        m_run;
  logic [3:0]  tgt;
  logic [3:0]  oth;

  mole_game_if #(.N_CH(16)) io ();

  mole_game_core #(
    .N_CH      (16),
    .CLK_DIV   (4),
    .LFSR_W    (16),
    .LFSR_TAPS (TAPS),
    .LFSR_SEED (SEED),
    .WIN_SCORE (3),
    .MAX_MISS  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(
    input logic [15:0] x
  );
    if (x == 16'h0) return SEED;
    return {^(x & TAPS), x[15:1]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 2'd0;
      m_lfsr <= SEED;
      m_run  <= 1'b0;
    end else begin
      if (m_run) begin
        if (m_cnt == 2'd3) begin
          m_cnt  <= 2'd0;
          m_lfsr <= nxt(m_lfsr);
        end else begin
          m_cnt <= m_cnt + 2'd1;
        end
      end
      if (io.start) m_run <= 1'b1;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    io.start = 1'b1;
    step(1);
    io.start = 1'b0;
  endtask

  task automatic wait_show(input string tag);
    int n;
    n = 0;
    while (io.led == 16'h0 && n < 40) begin
      step(1);
      n++;
    end
    chk(tag, 32'(io.led != 16'h0), 32'd1);
    tgt = m_lfsr[3:0];
    chk({tag, "_oh"}, 32'(io.led),
        32'(16'h1 << tgt));
  endtask

  task automatic do_hit(input string tag);
    wait_show(tag);
    io.sw[tgt] = 1'b1;
    step(3);
    io.sw[tgt] = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    io.start = 1'b0;
    io.sw    = '0;
    step(3);
    rst = 1'b0;

    step(20);
    chk("rst_led", 32'(io.led), 32'h0);
    chk("rst_score", 32'(io.score), 32'h0);
    chk("rst_miss", 32'(io.misses), 32'h0);
    chk("rst_disp", 32'(io.disp), 32'h01);
    chk("rst_busy", 32'(io.busy), 32'h0);
    chk("rst_lfsr", 32'(dut.u_lfsr.q),
        32'(SEED));

    pulse_start();
    chk("arm_busy", 32'(io.busy), 32'h1);
    wait_show("show1");
    step(1);
    io.sw[tgt] = 1'b1;
    step(2);
    chk("hit_lat2", 32'(io.score), 32'h0);
    step(1);
    chk("hit_lat3", 32'(io.score), 32'h1);
    chk("hit_led", 32'(io.led), 32'h0);
    chk("hit_busy", 32'(io.busy), 32'h1);
    io.sw = '0;

    do_hit("show2");
    chk("hit2", 32'(io.score), 32'h2);
    do_hit("show3");
    chk("win_led", 32'(io.led), 32'hFFFF);
    chk("win_score", 32'(io.score), 32'h3);
    chk("win_disp", 32'(io.disp), 32'h06);
    chk("win_busy", 32'(io.busy), 32'h0);
    io.sw[3] = 1'b1;
    step(6);
    io.sw = '0;
    step(2);
    chk("win_hold", 32'(io.score), 32'h3);
    chk("win_hold_led", 32'(io.led), 32'hFFFF);

    pulse_start();
    chk("g2_score", 32'(io.score), 32'h0);
    wait_show("wr");
    oth = tgt + 4'd1;
    io.sw[oth] = 1'b1;
    step(3);
    chk("wrong_miss", 32'(io.misses), 32'h1);
    chk("wrong_score", 32'(io.score), 32'h0);
    chk("wrong_led", 32'(io.led), 32'h0);
    io.sw = '0;
    wait_show("to1");
    step(4);
    chk("tmo_miss2", 32'(io.misses), 32'h2);
    chk("tmo_led", 32'(io.led), 32'h0);
    wait_show("to2");
    step(4);
    chk("lose_miss", 32'(io.misses), 32'h3);
    chk("lose_led", 32'(io.led), 32'hAAAA);
    chk("lose_busy", 32'(io.busy), 32'h0);

    pulse_start();
    chk("g3_miss", 32'(io.misses), 32'h0);
    wait_show("both");
    oth = tgt ^ 4'h8;
    step(1);
    io.sw[tgt] = 1'b1;
    io.sw[oth] = 1'b1;
    step(3);
    chk("both_score", 32'(io.score), 32'h1);
    chk("both_miss", 32'(io.misses), 32'h0);
    chk("both_led", 32'(io.led), 32'h0);
    io.sw = '0;

    io.sw = '1;
    rst   = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    pulse_start();
    wait_show("held");
    step(2);
    chk("held_score", 32'(io.score), 32'h0);
    chk("held_miss", 32'(io.misses), 32'h0);
    step(2);
    chk("held_tmo", 32'(io.misses), 32'h1);
    wait_show("rerise");
    io.sw[tgt] = 1'b0;
    step(1);
    io.sw[tgt] = 1'b1;
    step(3);
    chk("rerise_hit", 32'(io.score), 32'h1);
    chk("rerise_miss", 32'(io.misses), 32'h1);

    wait_show("mid");
    rst = 1'b1;
    step(1);
    chk("mid_led", 32'(io.led), 32'h0);
    chk("mid_score", 32'(io.score), 32'h0);
    chk("mid_miss", 32'(io.misses), 32'h0);
    chk("mid_busy", 32'(io.busy), 32'h0);
    chk("mid_disp", 32'(io.disp), 32'h01);
    chk("mid_lfsr", 32'(dut.u_lfsr.q),
        32'(SEED));
    rst   = 1'b0;
    io.sw = '0;
    step(2);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
